pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 LE  input  1  pipeline advance enable from the hazard unit; 0 = stall, hold PC/NPC.
REQ-005 J  input  1  jump decision from the condition handler, qualified internally as described below.
REQ-006 NULL_N  input  1  nullify bit of the branch that produced J; 1 = squash the delay-slot instruction when taken.
REQ-007 TA  input  32  branch target address, valid while J=1.
REQ-008 PC  output  32  address of the instruction being fetched.
REQ-009 NPC  output  32  address of the next instruction (delay slot or target).
REQ-010 FLUSH  output  1  squash the instruction entering decode this cycle.
REQ-011 REDIRECT  output  1  single-cycle pulse when NPC is loaded from a branch target.
REQ-012 STATE  output  2  current state (00 RUN, 01 PEND, 10 NULL), for debug and coverage.

Function
REQ-013 The module SHALL update PC, NPC and state only on the rising edge of clk.
REQ-014 RUN, J=0, LE=1: the module SHALL load PC<=NPC and NPC<=NPC+4.
REQ-015 Any state, LE=0, no pending capture: the module SHALL hold PC and NPC.
REQ-016 RUN, J=1, LE=1: the module SHALL load PC<=NPC (delay slot), load NPC<=TA, and pulse REDIRECT for the next cycle.
REQ-017 In the REQ-016 case with NULL_N=1: the module SHALL go to NULL and assert FLUSH for exactly the one cycle in which the delay-slot instruction is fetched; otherwise it stays in RUN.
REQ-018 RUN, J=1, LE=0: the module SHALL latch TA and NULL_N into internal registers, go to PEND, and hold PC/NPC.
REQ-019 PEND, LE=0: the module SHALL hold PC, NPC and the latched values, and ignore J and TA.
REQ-020 PEND, LE=1: the module SHALL apply REQ-016/REQ-017 using the latched TA and NULL_N, not the live inputs.
REQ-021 NULL: the module SHALL ignore J, because a nullified instruction never branches.
REQ-022 NULL, LE=1: the module SHALL advance per REQ-014 and return to RUN.
REQ-023 NULL, LE=0: the module SHALL remain in NULL, hold PC/NPC, and keep FLUSH asserted until it advances.
REQ-024 NPC+4 SHALL be modulo 2^32, so 0xFFFFFFFC+4 wraps to 0x00000000 with no flag.
REQ-025 TA[1:0] SHALL be forced to 00 when loaded into NPC.
REQ-026 FLUSH and REDIRECT SHALL be registered outputs with no combinational path from J, LE or TA.
REQ-027 REDIRECT SHALL be 0 in every cycle not immediately following a target load.

Reset
REQ-028 When reset=1 at a clock edge, the module SHALL set PC=0x00000000, NPC=0x00000004, STATE=RUN, FLUSH=0 and REDIRECT=0, and clear the latched TA/NULL_N.
REQ-029 Reset SHALL take priority over LE, J and any state, including mid-PEND or mid-NULL.
REQ-030 In the first cycle after reset deassertion, the module SHALL behave as RUN with PC=0.

Verification
REQ-031 Sequential flow: reset, then LE=1, J=0 for 3 cycles -> PC 0,4,8,C and NPC 4,8,C,10.
REQ-032 Taken branch, no nullify: at PC=8, NPC=C, pulse J=1, TA=0x100, NULL_N=0, LE=1 -> next PC=C, NPC=0x100, REDIRECT=1, FLUSH=0; following PC=0x100, NPC=0x104.
REQ-033 Taken with nullify and stalled NULL: same as REQ-032 but NULL_N=1 -> FLUSH=1 with PC=C and STATE=NULL; then J=1, TA=0x200, LE=0 for 2 cycles -> J ignored, FLUSH stays 1, PC/NPC held; then LE=1 -> PC=0x100, FLUSH=0, STATE=RUN.
REQ-034 Branch during stall: J=1, TA=0x40, LE=0 -> STATE=PEND, PC held; change TA to 0x80 and hold LE=0 for 2 cycles, then LE=1 -> NPC=0x40 (latched value), REDIRECT=1.
REQ-035 Wrap and alignment: force NPC=0xFFFFFFFC via branch TA=0xFFFFFFFF -> NPC=0xFFFFFFFC; next advance -> PC=0xFFFFFFFC, NPC=0x00000000.
REQ-036 Reset mid-operation: assert reset while STATE=PEND -> next cycle PC=0, NPC=4, STATE=RUN, FLUSH=0, REDIRECT=0, and the old latched TA is never applied.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC/NPC sequencer with delay slot, stalled-branch capture and nullify
module pc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        LE,
    input  logic        J,
    input  logic        NULL_N,
    input  logic [31:0] TA,
    output logic [31:0] PC,
    output logic [31:0] NPC,
    output logic        FLUSH,
    output logic        REDIRECT,
    output logic [1:0]  STATE
);
    typedef enum logic [1:0] {S_RUN = 2'b00, S_PEND = 2'b01, S_NULL = 2'b10} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, npc_q, npc_d, ta_q, ta_d, br_ta;
    logic        nn_q, nn_d, br_nn, flush_q, flush_d, redirect_q, redirect_d;
    // next-state: a pending capture takes its latched target, otherwise the live branch inputs
    always_comb begin
        pc_d       = pc_q;
        npc_d      = npc_q;
        state_d    = state_q;
        ta_d       = ta_q;
        nn_d       = nn_q;
        redirect_d = 1'b0;
        br_ta      = (state_q == S_PEND) ? ta_q : TA;
        br_nn      = (state_q == S_PEND) ? nn_q : NULL_N;
        if (state_q == S_NULL) begin
            if (LE) begin
                pc_d    = npc_q;
                npc_d   = npc_q + 32'd4;
                state_d = S_RUN;
            end
        end else if (state_q == S_PEND || J) begin
            if (LE) begin
                pc_d       = npc_q;
                npc_d      = br_ta & ~32'h3;
                redirect_d = 1'b1;
                state_d    = br_nn ? S_NULL : S_RUN;
            end else if (state_q != S_PEND) begin
                ta_d    = TA;
                nn_d    = NULL_N;
                state_d = S_PEND;
            end
        end else if (LE) begin
            pc_d  = npc_q;
            npc_d = npc_q + 32'd4;
        end
        flush_d = (state_d == S_NULL);
    end
    // state registers; reset overrides everything, including PEND and NULL
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= 32'h0;
            npc_q      <= 32'h4;
            state_q    <= S_RUN;
            ta_q       <= 32'h0;
            nn_q       <= 1'b0;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            state_q    <= state_d;
            ta_q       <= ta_d;
            nn_q       <= nn_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
        end
    end
    assign PC       = pc_q;
    assign NPC      = npc_q;
    assign FLUSH    = flush_q;
    assign REDIRECT = redirect_q;
    assign STATE    = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench with directed scenarios and randomized traffic
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset, LE, J, NULL_N;
    logic [31:0] TA, PC, NPC;
    logic        FLUSH, REDIRECT;
    logic [1:0]  STATE;
    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        flush;
        logic        redirect;
        logic [1:0]  state;
    } exp_t;
    exp_t q[$];

    // reference model: fetch pair plus "branch waiting" and "squashing" flags
    logic [31:0] m_pc = 0, m_npc = 4, m_ta = 0;
    bit m_pend = 0, m_nn = 0, m_sq = 0, m_redir = 0;

    pc_sequencer dut (.clk(clk), .reset(reset), .LE(LE), .J(J), .NULL_N(NULL_N), .TA(TA),
                      .PC(PC), .NPC(NPC), .FLUSH(FLUSH), .REDIRECT(REDIRECT), .STATE(STATE));

    always #5 clk = ~clk;

    task automatic model(input bit r, input bit le, input bit j, input bit nn, input logic [31:0] ta);
        m_redir = 0;
        if (r) begin
            m_pc = 0; m_npc = 4; m_pend = 0; m_ta = 0; m_nn = 0; m_sq = 0;
        end else if (m_sq) begin
            if (le) begin m_pc = m_npc; m_npc = m_npc + 4; m_sq = 0; end
        end else if (m_pend || j) begin
            if (!m_pend) begin m_ta = ta; m_nn = nn; end
            if (le) begin
                m_pc = m_npc; m_npc = {m_ta[31:2], 2'b00}; m_redir = 1; m_sq = m_nn; m_pend = 0;
            end else m_pend = 1;
        end else if (le) begin
            m_pc = m_npc; m_npc = m_npc + 4;
        end
    endtask

    task automatic step(input bit r, input bit le, input bit j, input bit nn, input logic [31:0] ta);
        exp_t e;
        @(negedge clk);
        reset = r; LE = le; J = j; NULL_N = nn; TA = ta;
        @(posedge clk);
        model(r, le, j, nn, ta);
        e.pc = m_pc; e.npc = m_npc; e.flush = m_sq; e.redirect = m_redir;
        e.state = m_sq ? 2'd2 : (m_pend ? 2'd1 : 2'd0);
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // after each step, let outputs settle then check the directed constant
    task automatic dchk(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
        chk(name, act_sel, exp);
    endtask

    // monitor: compare every registered output against the scoreboard once per cycle
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc", PC, e.pc);
            chk("npc", NPC, e.npc);
            chk("flush", {31'b0, FLUSH}, {31'b0, e.flush});
            chk("redirect", {31'b0, REDIRECT}, {31'b0, e.redirect});
            chk("state", {30'b0, STATE}, {30'b0, e.state});
        end
    end

    initial begin
        reset = 1; LE = 0; J = 0; NULL_N = 0; TA = 0;
        // sequential flow
        step(1, 0, 0, 0, 0); #1 dchk("rst_pc", PC, 32'h0); dchk("rst_npc", NPC, 32'h4);
        step(0, 1, 0, 0, 0); #1 dchk("seq1_pc", PC, 32'h4);
        step(0, 1, 0, 0, 0); #1 dchk("seq2_pc", PC, 32'h8);
        step(0, 1, 0, 0, 0); #1 dchk("seq3_pc", PC, 32'hC); dchk("seq3_npc", NPC, 32'h10);
        // taken branch, no nullify
        step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 32'h100); #1 dchk("br_pc", PC, 32'hC); dchk("br_npc", NPC, 32'h100);
        dchk("br_redir", {31'b0, REDIRECT}, 1); dchk("br_flush", {31'b0, FLUSH}, 0);
        step(0, 1, 0, 0, 0); #1 dchk("br_next_pc", PC, 32'h100); dchk("br_redir_off", {31'b0, REDIRECT}, 0);
        // taken with nullify, stalled in NULL
        step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 32'h100); #1 dchk("nul_flush", {31'b0, FLUSH}, 1); dchk("nul_state", {30'b0, STATE}, 2);
        step(0, 0, 1, 0, 32'h200); step(0, 0, 1, 0, 32'h200);
        #1 dchk("nul_hold_pc", PC, 32'hC); dchk("nul_hold_flush", {31'b0, FLUSH}, 1);
        step(0, 1, 0, 0, 0); #1 dchk("nul_exit_pc", PC, 32'h100); dchk("nul_exit_state", {30'b0, STATE}, 0);
        // branch during stall uses the latched target
        step(0, 0, 1, 0, 32'h40); #1 dchk("pend_state", {30'b0, STATE}, 1); dchk("pend_pc", PC, 32'h100);
        step(0, 0, 1, 0, 32'h80); step(0, 0, 0, 0, 32'h80);
        step(0, 1, 1, 1, 32'h80); #1 dchk("pend_npc", NPC, 32'h40); dchk("pend_redir", {31'b0, REDIRECT}, 1);
        // wrap and alignment
        step(0, 1, 1, 0, 32'hFFFF_FFFF); #1 dchk("align_npc", NPC, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0); #1 dchk("wrap_pc", PC, 32'hFFFF_FFFC); dchk("wrap_npc", NPC, 32'h0);
        // reset while pending discards the captured target
        step(0, 0, 1, 0, 32'h300); #1 dchk("pend2_state", {30'b0, STATE}, 1);
        step(1, 1, 1, 1, 32'h300); #1 dchk("rst_pend_npc", NPC, 32'h4); dchk("rst_pend_state", {30'b0, STATE}, 0);
        step(0, 1, 0, 0, 0); #1 dchk("rst_pend_after", NPC, 32'h8);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ta;
            ta = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, ta);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            vectors++; miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
